button_debouncer: RTL and testbench

Filters a raw, asynchronous pushbutton or switch input into a clean, glitch-free level. It sits between the board input pin and the level-to-pulse stage, driving that stage's `level` input. The input is optionally synchronised, then must hold a new value for a fixed number of consecutive clock cycles before the output level changes. Bounces shorter than that window are rejected.

---
 rtl/button_debouncer.sv | 139 +++++++++++++
 tb/tb_button_debouncer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// Turns a raw, bouncing pushbutton/switch input into a clean level. A new
// input value must be seen for STABLE_CYCLES consecutive samples before the
// output level follows it. Any sample that matches the current level during
// that window abandons the candidate change.
//
// Parameters:
//   STABLE_CYCLES  consecutive samples needed to accept a change (>= 2)
//   CNT_W          qualification counter width, must hold STABLE_CYCLES-1
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active low
//   button    in   raw asynchronous input
//   level     out  debounced level (state decode, registered)
//   bouncing  out  high while a candidate change is being timed (registered)
//
// Build option:
//   DEBOUNCE_SYNC_EN  when defined, button passes through a two-flop
//                     synchroniser before the FSM (two extra cycles of
//                     latency). Leave undefined only for inputs already
//                     synchronous to clk.
// ---------------------------------------------------------------------------
module button_debouncer #(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic bouncing
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             s;

`ifdef DEBOUNCE_SYNC_EN
  logic sync1;
  logic sync2;

  // Two-flop synchroniser; both stages clear on reset so a held button is
  // re-qualified from scratch once reset is released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = button;
`endif

  // State and qualification counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE_LOW;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The counter counts differing samples seen so far, starting at 1 on the
  // first one. It is cleared on accept or abort, so reaching CNT_MAX is the
  // only way out of a WAIT state upward and it can never wrap.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE_LOW: begin
        cnt_next = '0;
        if (s) begin
          state_next = WAIT_HIGH;
          cnt_next   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = IDLE_HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      IDLE_HIGH: begin
        cnt_next = '0;
        if (!s) begin
          state_next = WAIT_LOW;
          cnt_next   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_next = IDLE_HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are pure decodes of the state register, so nothing from button
  // reaches them combinationally.
  assign level    = (state == IDLE_HIGH) || (state == WAIT_LOW);
  assign bouncing = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer
//
// Self-checking bench for button_debouncer with STABLE_CYCLES = 4. Works in
// both builds: LAT is the synchroniser delay (2 with DEBOUNCE_SYNC_EN, else
// 0). The vector table is written for the direct-sample build; with the
// synchroniser the whole output trajectory is simply LAT cycles later.
// ---------------------------------------------------------------------------
module tb_button_debouncer;

`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int NVEC = 41;

  logic clk;
  logic rst;
  logic button;
  logic level;
  logic bouncing;

  int vectors;
  int miscompares;

  typedef struct {
    logic       button;
    logic       exp_level;
    logic       exp_bouncing;
    logic [1:0] exp_cnt;
  } vec_t;

  vec_t vecs [NVEC];

  button_debouncer #(.STABLE_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .button   (button),
    .level    (level),
    .bouncing (bouncing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so a broken DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setVec(input int i, input logic b, input logic l,
                        input logic bo, input logic [1:0] c);
    vecs[i].button       = b;
    vecs[i].exp_level    = l;
    vecs[i].exp_bouncing = bo;
    vecs[i].exp_cnt      = c;
  endtask

  // Drive button away from the edge, clock once, sample 1 ns later.
  task automatic applyStimulus(input logic b);
    button = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic el,
                             input logic eb, input logic [1:0] ec);
    vectors++;
    if (level !== el || bouncing !== eb || dut.cnt !== ec) begin
      miscompares++;
      $display("[TB] FAIL %s[%0d]: got level=%b bouncing=%b cnt=%0d, want level=%b bouncing=%b cnt=%0d",
               name, idx, level, bouncing, dut.cnt, el, eb, ec);
    end
  endtask

  // From reset release with button held high: full qualification latency.
  // Edge e=0 is the first edge after release.
  task automatic runLatency(input string name);
    logic       el;
    logic       eb;
    logic [1:0] ec;
    rst = 1'b1;
    for (int e = 0; e <= LAT + 4; e++) begin
      applyStimulus(1'b1);
      el = (e >= LAT + 3);
      eb = (e >= LAT) && (e < LAT + 3);
      ec = (e >= LAT && e < LAT + 3) ? 2'(e - LAT + 1) : 2'd0;
      checkOutput(name, e, el, eb, ec);
    end
  endtask

  initial begin
    logic       el;
    logic       eb;
    logic [1:0] ec;
    bit         hit;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    button      = 1'b0;

    // Clean press (level at 4th high sample), hold, clean release.
    setVec( 0,0,0,0,0); setVec( 1,1,0,1,1); setVec( 2,1,0,1,2); setVec( 3,1,0,1,3);
    setVec( 4,1,1,0,0); setVec( 5,1,1,0,0); setVec( 6,1,1,0,0); setVec( 7,1,1,0,0);
    setVec( 8,1,1,0,0); setVec( 9,1,1,0,0); setVec(10,1,1,0,0); setVec(11,0,1,1,1);
    setVec(12,0,1,1,2); setVec(13,0,1,1,3); setVec(14,0,0,0,0); setVec(15,0,0,0,0);
    // Bounce rejection: 1,1,1,0,1,1,0 then steady 0.
    setVec(16,1,0,1,1); setVec(17,1,0,1,2); setVec(18,1,0,1,3); setVec(19,0,0,0,0);
    setVec(20,1,0,1,1); setVec(21,1,0,1,2); setVec(22,0,0,0,0); setVec(23,0,0,0,0);
    setVec(24,0,0,0,0);
    // Bounce then settle high: 1,0,1,1,1,1.
    setVec(25,1,0,1,1); setVec(26,0,0,0,0); setVec(27,1,0,1,1); setVec(28,1,0,1,2);
    setVec(29,1,0,1,3); setVec(30,1,1,0,0); setVec(31,1,1,0,0);
    // Mirror case while high: 0,1 bounce then settle low.
    setVec(32,0,1,1,1); setVec(33,1,1,0,0); setVec(34,0,1,1,1); setVec(35,0,1,1,2);
    setVec(36,0,1,1,3); setVec(37,0,0,0,0); setVec(38,0,0,0,0); setVec(39,0,0,0,0);
    setVec(40,0,0,0,0);

    // Reset with button low.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0);
      checkOutput("reset_low", i, 1'b0, 1'b0, 2'd0);
    end
    rst = 1'b1;

    // Table run; expected values are shifted by the synchroniser delay.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].button);
      if (i >= LAT) begin
        el = vecs[i-LAT].exp_level;
        eb = vecs[i-LAT].exp_bouncing;
        ec = vecs[i-LAT].exp_cnt;
      end else begin
        el = 1'b0;
        eb = 1'b0;
        ec = 2'd0;
      end
      checkOutput("table", i, el, eb, ec);
    end

    // Reset held 3 edges with button high, then full latency after release.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1);
      checkOutput("reset_high", i, 1'b0, 1'b0, 2'd0);
    end
    runLatency("post_reset");

    // Return to a low level, then reset in the middle of a count.
    rst = 1'b0;
    applyStimulus(1'b0);
    rst = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      applyStimulus(1'b0);
      checkOutput("settle_low", i, 1'b0, 1'b0, 2'd0);
    end
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      applyStimulus(1'b1);
      if (dut.cnt == 2'd2) hit = 1'b1;
    end
    if (!hit) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL midreset_wait: got cnt=%0d after 20 cycles, want cnt=2", dut.cnt);
    end
    rst = 1'b0;
    applyStimulus(1'b1);
    checkOutput("midreset", 0, 1'b0, 1'b0, 2'd0);
    runLatency("after_midreset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
